difftest_commit_queue: RTL and testbench

Multi-lane instruction-commit buffer between the core's retire stage and the difftest `DifftestInstrCommit` channels in `SimTop`. Accepts up to `NCOMMIT` retired instructions per cycle on sparse lanes, compacts them in program order into a `DEPTH`-entry FIFO, and drains up to `NCOMMIT` per cycle onto dense, registered output lanes. Output lane *i* maps to commit `index` *i*. This replaces the single-lane, one-cycle delay registers and adds back-pressure, a hold input, and a commit counter.

---
 rtl/difftest_commit_queue_if.sv | 29 ++
 rtl/difftest_commit_queue.sv | 155 +++++++++++++++
 tb/tb_difftest_commit_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/difftest_commit_queue_if.sv
// Retire-side input lanes, hold, and dense difftest-side output lanes of the commit queue.
interface difftest_commit_queue_if #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 64
);
  logic [NCOMMIT-1:0]           in_valid;
  logic                         in_ready;
  logic [NCOMMIT-1:0][31:0]     in_pc;
  logic [NCOMMIT-1:0][31:0]     in_instr;
  logic [NCOMMIT-1:0]           in_wen;
  logic [NCOMMIT-1:0][4:0]      in_wdest;
  logic [NCOMMIT-1:0][XLEN-1:0] in_wdata;
  logic                         hold;
  logic [NCOMMIT-1:0]           out_valid;
  logic [NCOMMIT-1:0][31:0]     out_pc;
  logic [NCOMMIT-1:0][31:0]     out_instr;
  logic [NCOMMIT-1:0]           out_wen;
  logic [NCOMMIT-1:0][7:0]      out_wdest;
  logic [NCOMMIT-1:0][XLEN-1:0] out_wdata;

  modport master (
    output in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, hold,
    input  in_ready, out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata
  );
  modport slave (
    input  in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, hold,
    output in_ready, out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// Multi-lane retire-to-difftest commit FIFO: compacting push, dense registered pop.
// Optional DIFFTEST_COMMIT_SKIP_X0_EN drops wen for writes to x0 at push time.
module difftest_commit_lane #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ld,
  input  logic [31:0]     pc,
  input  logic [31:0]     instr,
  input  logic            wen,
  input  logic [4:0]      wdest,
  input  logic [XLEN-1:0] wdata,
  output logic            q_valid,
  output logic [31:0]     q_pc,
  output logic [31:0]     q_instr,
  output logic            q_wen,
  output logic [7:0]      q_wdest,
  output logic [XLEN-1:0] q_wdata
);
  // Payload of an idle lane keeps its last value; only valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_instr <= '0;
      q_wen   <= 1'b0;
      q_wdest <= '0;
      q_wdata <= '0;
    end else begin
      q_valid <= ld;
      if (ld) begin
        q_pc    <= pc;
        q_instr <= instr;
        q_wen   <= wen;
        q_wdest <= {3'b0, wdest};
        q_wdata <= wdata;
      end
    end
  end
endmodule

module difftest_commit_queue #(
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  difftest_commit_queue_if.slave     io,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [63:0]                commit_total,
  output logic                       overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t [NCOMMIT-1:0] in_ent;
  logic [NCOMMIT-1:0][PW-1:0] offs;
  logic [CW-1:0] n_push, pushed, n_pop, count_next;
  logic do_push;

  // Offset of each valid lane within the compacted write group.
  always_comb begin
    n_push = '0;
    offs   = '0;
    in_ent = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      offs[i]         = PW'(n_push);
      n_push          = n_push + CW'(io.in_valid[i]);
      in_ent[i].pc    = io.in_pc[i];
      in_ent[i].instr = io.in_instr[i];
      in_ent[i].wdest = io.in_wdest[i];
      in_ent[i].wdata = io.in_wdata[i];
`ifdef DIFFTEST_COMMIT_SKIP_X0_EN
      in_ent[i].wen   = io.in_wen[i] && (io.in_wdest[i] != 5'd0);
`else
      in_ent[i].wen   = io.in_wen[i];
`endif
    end
  end

  assign do_push    = io.in_ready && (|io.in_valid);
  assign pushed     = do_push ? n_push : '0;
  // Pop decision uses pre-edge count: same-edge pushes wait one cycle.
  assign n_pop      = io.hold ? '0 : ((count < CW'(NCOMMIT)) ? count : CW'(NCOMMIT));
  assign count_next = count + pushed - n_pop;

  always_ff @(posedge clock) begin
    if (do_push)
      for (int i = 0; i < NCOMMIT; i++)
        if (io.in_valid[i]) mem[wr_ptr + offs[i]] <= in_ent[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      io.in_ready  <= 1'b1;
      commit_total <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr       <= rd_ptr + PW'(n_pop);
      count        <= count_next;
      io.in_ready  <= count_next <= CW'(DEPTH - NCOMMIT);
      commit_total <= commit_total + 64'(n_pop);
      if ((|io.in_valid) && !io.in_ready) overflow_err <= 1'b1;
    end
  end

  logic [NCOMMIT-1:0]           o_valid, o_wen;
  logic [NCOMMIT-1:0][31:0]     o_pc, o_instr;
  logic [NCOMMIT-1:0][7:0]      o_wdest;
  logic [NCOMMIT-1:0][XLEN-1:0] o_wdata;

  for (genvar j = 0; j < NCOMMIT; j++) begin : g_lane
    entry_t rd_e;
    assign rd_e = mem[rd_ptr + PW'(j)];
    difftest_commit_lane #(.XLEN(XLEN)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .ld      (CW'(j) < n_pop),
      .pc      (rd_e.pc),
      .instr   (rd_e.instr),
      .wen     (rd_e.wen),
      .wdest   (rd_e.wdest),
      .wdata   (rd_e.wdata),
      .q_valid (o_valid[j]),
      .q_pc    (o_pc[j]),
      .q_instr (o_instr[j]),
      .q_wen   (o_wen[j]),
      .q_wdest (o_wdest[j]),
      .q_wdata (o_wdata[j])
    );
  end

  assign io.out_valid = o_valid;
  assign io.out_pc    = o_pc;
  assign io.out_instr = o_instr;
  assign io.out_wen   = o_wen;
  assign io.out_wdest = o_wdest;
  assign io.out_wdata = o_wdata;
endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (NCOMMIT=2, DEPTH=8, XLEN=64).
module tb_difftest_commit_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  count;
  logic [63:0] commit_total;
  logic        overflow_err;
  int          total = 0;
  int          bad   = 0;

  difftest_commit_queue_if #(.NCOMMIT(2), .XLEN(64)) io ();

  difftest_commit_queue #(.NCOMMIT(2), .DEPTH(8), .XLEN(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .io           (io),
    .count        (count),
    .commit_total (commit_total),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    io.in_valid = v;
    io.in_pc[0] = pc0;
    io.in_pc[1] = pc1;
    io.in_instr[0] = pc0 ^ 32'h13;
    io.in_instr[1] = pc1 ^ 32'h13;
  endtask

  logic [63:0] ct0;
  logic        exp_wen;

  initial begin
    reset = 1'b1;
    io.hold = 1'b0;
    io.in_wen = 2'b11;
    io.in_wdest[0] = 5'd5;
    io.in_wdest[1] = 5'd7;
    io.in_wdata[0] = 64'h2A;
    io.in_wdata[1] = 64'h55;
    drive(2'b00, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", io.out_valid, 2'b00);
    chk("rst_pc", io.out_pc, 64'h0);
    chk("rst_count", count, 0);
    chk("rst_ready", io.in_ready, 1);
    chk("rst_total", commit_total, 0);
    chk("rst_ovf", overflow_err, 0);

    // single lane-0 entry, latency t+2
    drive(2'b01, 32'h8000_0000, 32'hDEAD_BEEF);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("lat_t1_valid", io.out_valid, 2'b00);
    chk("lat_t1_count", count, 1);
    tick();
    chk("one_valid", io.out_valid, 2'b01);
    chk("one_pc", io.out_pc[0], 32'h8000_0000);
    chk("one_wdest", io.out_wdest[0], 8'h05);
    chk("one_wdata", io.out_wdata[0], 64'h2A);
    chk("one_total", commit_total, 1);

    // compaction: lane 1 only lands on output lane 0
    drive(2'b10, 32'h0, 32'h8000_0004);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    tick();
    chk("cmp_valid", io.out_valid, 2'b01);
    chk("cmp_pc", io.out_pc[0], 32'h8000_0004);
    chk("cmp_wdata", io.out_wdata[0], 64'h55);
    chk("cmp_total", commit_total, 2);

    // fill under hold
    io.hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("fill_ready", io.in_ready, 1);
      drive(2'b11, 32'h100 + 32'(8*c), 32'h104 + 32'(8*c));
      tick();
      chk("fill_valid", io.out_valid, 2'b00);
    end
    chk("full_count", count, 8);
    chk("full_ready", io.in_ready, 0);
    chk("pre_ovf", overflow_err, 0);
    drive(2'b11, 32'hBAD0, 32'hBAD4);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 8);
    io.hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drain_valid", io.out_valid, 2'b11);
      chk("drain_pc0", io.out_pc[0], 32'h100 + 32'(8*c));
      chk("drain_pc1", io.out_pc[1], 32'h104 + 32'(8*c));
      chk("drain_ready", io.in_ready, 1);
    end
    chk("drain_count", count, 0);
    chk("drain_total", commit_total, 10);
    tick();
    chk("drain_idle", io.out_valid, 2'b00);

    // partial fill to 7: ready drops early
    io.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 32'h180 + 32'(8*c), 32'h184 + 32'(8*c));
      tick();
    end
    drive(2'b01, 32'h198, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("p7_count", count, 7);
    chk("p7_ready", io.in_ready, 0);
    io.hold = 1'b0;
    tick(); tick(); tick();
    chk("p7_count1", count, 1);
    tick();
    chk("p7_last_valid", io.out_valid, 2'b01);
    chk("p7_last_pc", io.out_pc[0], 32'h198);
    chk("p7_total", commit_total, 17);
    chk("ovf_sticky", overflow_err, 1);

    // steady 2/cycle
    ct0 = commit_total;
    for (int n = 1; n <= 20; n++) begin
      drive(2'b11, 32'h200 + 32'(8*(n-1)), 32'h204 + 32'(8*(n-1)));
      tick();
      chk("st_count_le2", {63'b0, count <= 4'd2}, 64'd1);
      chk("st_ready", io.in_ready, 1);
      if (n >= 2) chk("st_pc0", io.out_pc[0], 32'h200 + 32'(8*(n-2)));
    end
    drive(2'b00, 32'h0, 32'h0);
    tick();
    chk("st_last_pc1", io.out_pc[1], 32'h204 + 32'(8*19));
    tick();
    chk("st_idle", io.out_valid, 2'b00);
    chk("st_total40", commit_total - ct0, 64'd40);

    // write to x0
`ifdef DIFFTEST_COMMIT_SKIP_X0_EN
    exp_wen = 1'b0;
`else
    exp_wen = 1'b1;
`endif
    io.in_wdest[0] = 5'd0;
    drive(2'b01, 32'h400, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    tick();
    chk("x0_valid", io.out_valid, 2'b01);
    chk("x0_wen", io.out_wen[0], exp_wen);
    chk("x0_wdest", io.out_wdest[0], 8'h00);
    io.in_wdest[0] = 5'd5;

    // reset with 5 buffered entries
    io.hold = 1'b1;
    drive(2'b11, 32'h500, 32'h504); tick();
    drive(2'b11, 32'h508, 32'h50C); tick();
    drive(2'b01, 32'h510, 32'h0);   tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("pre_rst_count", count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    io.hold = 1'b0;
    chk("mrst_valid", io.out_valid, 2'b00);
    chk("mrst_count", count, 0);
    chk("mrst_ready", io.in_ready, 1);
    chk("mrst_ovf", overflow_err, 0);
    chk("mrst_total", commit_total, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_no_stale", io.out_valid, 2'b00);
    end
    drive(2'b01, 32'h600, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    tick();
    chk("mrst_new_valid", io.out_valid, 2'b01);
    chk("mrst_new_pc", io.out_pc[0], 32'h600);
    tick();
    chk("mrst_end_valid", io.out_valid, 2'b00);
    chk("mrst_end_total", commit_total, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
